// File: rtl/sdram_resp_if.sv
// rtl/sdram_resp_if.sv - SDRAM command/data bus between controller and responder model
interface sdram_resp_if;
    logic        sd_cs;
    logic        sd_ras;
    logic        sd_cas;
    logic        sd_we;
    logic [12:0] sd_addr;
    logic [1:0]  sd_ba;
    logic [1:0]  sd_dqm;
    logic [15:0] sd_din;
    logic [15:0] sd_dout;
    logic        sd_doe;

    modport master (
        output sd_cs, sd_ras, sd_cas, sd_we, sd_addr, sd_ba, sd_dqm, sd_din,
        input  sd_dout, sd_doe
    );

    modport slave (
        input  sd_cs, sd_ras, sd_cas, sd_we, sd_addr, sd_ba, sd_dqm, sd_din,
        output sd_dout, sd_doe
    );
endinterface

// File: rtl/sdram_resp.sv
// rtl/sdram_resp.sv - behavioural SDRAM responder: bank tracking, mode register, bursts, CAS-latency read pipe
module sdram_resp #(
    parameter int ROW_BITS = 4,
    parameter int COL_BITS = 4
) (
    input  logic               clk,
    input  logic               init,
    sdram_resp_if.slave        sd,
    output logic               err,
    output logic [15:0]        refresh_cnt
);
    localparam int AW = 2 + ROW_BITS + COL_BITS;

    localparam logic [3:0] C_LMR = 4'b0000;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_BT  = 4'b0110;

    logic [15:0]         mem_q [2**AW];
    logic [3:0]          act_q, act_d;
    logic [ROW_BITS-1:0] row_q [4];
    logic [ROW_BITS-1:0] row_d [4];
    logic [2:0]          cl_q, cl_d, bl_q, bl_d;
    logic                ws_q, ws_d, err_q, err_d;
    logic [15:0]         ref_q, ref_d;
    logic                bst_q, bst_d, bwr_q, bwr_d, bap_q, bap_d;
    logic [1:0]          bba_q, bba_d;
    logic [COL_BITS-1:0] bcol_q, bcol_d;
    logic [2:0]          bidx_q, bidx_d, blast_q, blast_d;
    logic                p1v_q, p1v_d, p2v_q, p2v_d, doe_q, doe_d;
    logic [15:0]         p1d_q, p1d_d, p2d_q, p2d_d, dout_q, dout_d;

    logic [3:0]          cmd;
    logic [1:0]          ba;
    logic                a10, rd_ok, wr_ok, term, flush, rd_issue, mem_we, nv;
    logic [2:0]          bl_m1, len_m1;
    logic [AW-1:0]       acc_a, rd_a, mem_wa;
    logic [15:0]         mem_old, mem_wd, rd_data, nd;
    logic                unused_addr;

    // Sequential burst order: low log2(BL) column bits count and wrap inside the aligned block
    function automatic logic [COL_BITS-1:0] burst_col(input logic [COL_BITS-1:0] start,
                                                      input logic [2:0] idx, input logic [2:0] last);
        logic [COL_BITS-1:0] mask, sum;
        mask = COL_BITS'(last);
        sum  = start + COL_BITS'(idx);
        return (start & ~mask) | (sum & mask);
    endfunction

    assign unused_addr = ^sd.sd_addr;

    always_comb begin
        cmd = {sd.sd_cs, sd.sd_ras, sd.sd_cas, sd.sd_we};
        ba  = sd.sd_ba;
        a10 = sd.sd_addr[10];
        case (bl_q)
            3'd0:    bl_m1 = 3'd0;
            3'd1:    bl_m1 = 3'd1;
            3'd2:    bl_m1 = 3'd3;
            default: bl_m1 = 3'd7;
        endcase
        act_d = act_q;  row_d = row_q;
        cl_d = cl_q;    bl_d = bl_q;    ws_d = ws_q;
        err_d = err_q;  ref_d = ref_q;
        bst_d = bst_q;  bwr_d = bwr_q;  bap_d = bap_q;  bba_d = bba_q;
        bcol_d = bcol_q; bidx_d = bidx_q; blast_d = blast_q;
        acc_a = '0; rd_a = '0; mem_wa = '0; len_m1 = 3'd0;
        rd_issue = 1'b0; mem_we = 1'b0; flush = 1'b0;

        rd_ok = (cmd == C_RD) && act_q[ba];
        wr_ok = (cmd == C_WR) && act_q[ba];
        term  = rd_ok || wr_ok || (cmd == C_BT) || ((cmd == C_PRE) && (a10 || ba == bba_q));

        if (bst_q && !term) begin
            acc_a = {bba_q, row_q[bba_q], burst_col(bcol_q, bidx_q, blast_q)};
            if (bwr_q) begin
                mem_we = 1'b1;
                mem_wa = acc_a;
            end else begin
                rd_issue = 1'b1;
                rd_a     = acc_a;
            end
            bidx_d = bidx_q + 3'd1;
            if (bidx_q == blast_q) begin
                bst_d = 1'b0;
                if (bap_q) act_d[bba_q] = 1'b0;
            end
        end else if (term) begin
            bst_d = 1'b0;
        end

        case (cmd)
            C_ACT: begin
                if (act_q[ba]) err_d = 1'b1;
                else begin
                    act_d[ba] = 1'b1;
                    row_d[ba] = sd.sd_addr[ROW_BITS-1:0];
                end
            end
            C_RD, C_WR: begin
                if (!act_q[ba]) err_d = 1'b1;
                else begin
                    acc_a = {ba, row_q[ba], sd.sd_addr[COL_BITS-1:0]};
                    if (cmd == C_WR) begin
                        mem_we = 1'b1;
                        mem_wa = acc_a;
                        flush  = 1'b1;
                        len_m1 = ws_q ? 3'd0 : bl_m1;
                    end else begin
                        rd_issue = 1'b1;
                        rd_a     = acc_a;
                        len_m1   = bl_m1;
                    end
                    if (len_m1 == 3'd0) begin
                        if (a10) act_d[ba] = 1'b0;
                    end else begin
                        bst_d   = 1'b1;
                        bwr_d   = (cmd == C_WR);
                        bap_d   = a10;
                        bba_d   = ba;
                        bcol_d  = sd.sd_addr[COL_BITS-1:0];
                        bidx_d  = 3'd1;
                        blast_d = len_m1;
                    end
                end
            end
            C_PRE: begin
                if (a10) act_d = '0;
                else act_d[ba] = 1'b0;
            end
            C_REF: begin
                if (|act_q) err_d = 1'b1;
                else ref_d = ref_q + 16'd1;
            end
            C_LMR: begin
                if ((|act_q) || !(sd.sd_addr[6:4] == 3'd2 || sd.sd_addr[6:4] == 3'd3) || sd.sd_addr[2])
                    err_d = 1'b1;
                else begin
                    cl_d = sd.sd_addr[6:4];
                    bl_d = sd.sd_addr[2:0];
                    ws_d = sd.sd_addr[9];
                end
            end
            default: ;
        endcase

        mem_old = mem_q[mem_wa];
        mem_wd  = {sd.sd_dqm[1] ? mem_old[15:8] : sd.sd_din[15:8],
                   sd.sd_dqm[0] ? mem_old[7:0]  : sd.sd_din[7:0]};
        rd_data = mem_q[rd_a];

        // Word issued at edge N leaves the pipe CL-1 edges later; a write owns the bus and drops it
        p1v_d = rd_issue;
        p1d_d = rd_issue ? rd_data : 16'd0;
        p2v_d = p1v_q;
        p2d_d = p1d_q;
        nv    = (cl_q == 3'd3) ? p2v_q : p1v_q;
        nd    = (cl_q == 3'd3) ? p2d_q : p1d_q;
        if (flush) begin
            p1v_d = 1'b0;
            p2v_d = 1'b0;
            nv    = 1'b0;
        end
        doe_d  = nv;
        dout_d = nv ? nd : 16'd0;
    end

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            act_q <= '0;
            for (int i = 0; i < 4; i++) row_q[i] <= '0;
            cl_q <= 3'd2;  bl_q <= 3'd0;  ws_q <= 1'b0;
            err_q <= 1'b0; ref_q <= 16'd0;
            bst_q <= 1'b0; bwr_q <= 1'b0; bap_q <= 1'b0; bba_q <= 2'd0;
            bcol_q <= '0;  bidx_q <= 3'd0; blast_q <= 3'd0;
            p1v_q <= 1'b0; p1d_q <= 16'd0; p2v_q <= 1'b0; p2d_q <= 16'd0;
            doe_q <= 1'b0; dout_q <= 16'd0;
        end else begin
            act_q <= act_d;
            row_q <= row_d;
            cl_q <= cl_d;  bl_q <= bl_d;  ws_q <= ws_d;
            err_q <= err_d; ref_q <= ref_d;
            bst_q <= bst_d; bwr_q <= bwr_d; bap_q <= bap_d; bba_q <= bba_d;
            bcol_q <= bcol_d; bidx_q <= bidx_d; blast_q <= blast_d;
            p1v_q <= p1v_d; p1d_q <= p1d_d; p2v_q <= p2v_d; p2d_q <= p2d_d;
            doe_q <= doe_d; dout_q <= dout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !init) mem_q[mem_wa] <= mem_wd;
    end

    assign sd.sd_dout   = dout_q;
    assign sd.sd_doe    = doe_q;
    assign err          = err_q;
    assign refresh_cnt  = ref_q;
endmodule

// File: tb/tb_sdram_resp.sv
// tb/tb_sdram_resp.sv - directed vector table plus hand sequences for the SDRAM responder
module tb_sdram_resp;
    logic        clk = 1'b0;
    logic        init;
    logic        err;
    logic [15:0] refresh_cnt;

    sdram_resp_if sd();

    sdram_resp #(.ROW_BITS(4), .COL_BITS(4)) dut (
        .clk         (clk),
        .init        (init),
        .sd          (sd.slave),
        .err         (err),
        .refresh_cnt (refresh_cnt)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] C_LMR = 4'd0, C_REF = 4'd1, C_PRE = 4'd2, C_ACT = 4'd3;
    localparam logic [3:0] C_WR  = 4'd4, C_RD  = 4'd5, C_BT  = 4'd6, C_NOP = 4'd7;

    typedef struct {
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] addr;
        logic [1:0]  dqm;
        logic [15:0] din;
        logic        doe;
        logic [15:0] dout;
        logic        err;
        logic [15:0] rcnt;
    } vec_t;

    vec_t tbl[$];
    int checks = 0;
    int errors = 0;

    function automatic vec_t v(input logic [3:0] cmd, input logic [1:0] ba, input logic [12:0] addr,
                               input logic [1:0] dqm, input logic [15:0] din, input logic doe,
                               input logic [15:0] dout, input logic e, input logic [15:0] rcnt);
        vec_t r;
        r.cmd = cmd; r.ba = ba; r.addr = addr; r.dqm = dqm; r.din = din;
        r.doe = doe; r.dout = dout; r.err = e; r.rcnt = rcnt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] cmd, input logic [1:0] ba, input logic [12:0] addr,
                         input logic [1:0] dqm, input logic [15:0] din);
        {sd.sd_cs, sd.sd_ras, sd.sd_cas, sd.sd_we} = cmd;
        sd.sd_ba   = ba;
        sd.sd_addr = addr;
        sd.sd_dqm  = dqm;
        sd.sd_din  = din;
    endtask

    task automatic step(input logic [3:0] cmd, input logic [1:0] ba, input logic [12:0] addr,
                        input logic [1:0] dqm, input logic [15:0] din);
        @(negedge clk);
        drive(cmd, ba, addr, dqm, din);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // cmd, ba, addr, dqm, din | doe, dout, err, refresh_cnt after the edge
        tbl.push_back(v(C_LMR, 0, 13'h220, 0, 0,        0, 16'h0,    0, 0));
        tbl.push_back(v(C_ACT, 0, 13'h005, 0, 0,        0, 16'h0,    0, 0));
        tbl.push_back(v(C_WR,  0, 13'h003, 0, 16'hA55A, 0, 16'h0,    0, 0));
        tbl.push_back(v(C_RD,  0, 13'h003, 0, 0,        0, 16'h0,    0, 0));
        tbl.push_back(v(C_NOP, 0, 13'h000, 0, 0,        1, 16'hA55A, 0, 0));
        tbl.push_back(v(C_NOP, 0, 13'h000, 0, 0,        0, 16'h0,    0, 0));
        tbl.push_back(v(C_WR,  0, 13'h002, 0, 16'h1234, 0, 16'h0,    0, 0));
        tbl.push_back(v(C_WR,  0, 13'h002, 2, 16'hFFFF, 0, 16'h0,    0, 0));
        tbl.push_back(v(C_RD,  0, 13'h002, 3, 0,        0, 16'h0,    0, 0));
        tbl.push_back(v(C_NOP, 0, 13'h000, 0, 0,        1, 16'h12FF, 0, 0));
        tbl.push_back(v(C_NOP, 0, 13'h000, 0, 0,        0, 16'h0,    0, 0));
        tbl.push_back(v(C_PRE, 0, 13'h000, 0, 0,        0, 16'h0,    0, 0));
        tbl.push_back(v(C_LMR, 0, 13'h032, 0, 0,        0, 16'h0,    0, 0));
        tbl.push_back(v(C_ACT, 0, 13'h005, 0, 0,        0, 16'h0,    0, 0));
        tbl.push_back(v(C_WR,  0, 13'h004, 0, 16'h1111, 0, 16'h0,    0, 0));
        tbl.push_back(v(C_NOP, 0, 13'h000, 0, 16'h2222, 0, 16'h0,    0, 0));
        tbl.push_back(v(C_NOP, 0, 13'h000, 0, 16'h3333, 0, 16'h0,    0, 0));
        tbl.push_back(v(C_NOP, 0, 13'h000, 0, 16'h4444, 0, 16'h0,    0, 0));
        tbl.push_back(v(C_RD,  0, 13'h006, 0, 0,        0, 16'h0,    0, 0));
        tbl.push_back(v(C_NOP, 0, 13'h000, 0, 0,        0, 16'h0,    0, 0));
        tbl.push_back(v(C_NOP, 0, 13'h000, 0, 0,        1, 16'h3333, 0, 0));
        tbl.push_back(v(C_NOP, 0, 13'h000, 0, 0,        1, 16'h4444, 0, 0));
        tbl.push_back(v(C_NOP, 0, 13'h000, 0, 0,        1, 16'h1111, 0, 0));
        tbl.push_back(v(C_NOP, 0, 13'h000, 0, 0,        1, 16'h2222, 0, 0));
        tbl.push_back(v(C_NOP, 0, 13'h000, 0, 0,        0, 16'h0,    0, 0));
        tbl.push_back(v(C_RD,  0, 13'h004, 0, 0,        0, 16'h0,    0, 0));
        tbl.push_back(v(C_NOP, 0, 13'h000, 0, 0,        0, 16'h0,    0, 0));
        tbl.push_back(v(C_WR,  0, 13'h000, 0, 16'h5555, 0, 16'h0,    0, 0));
        tbl.push_back(v(C_NOP, 0, 13'h000, 0, 16'h6666, 0, 16'h0,    0, 0));
        tbl.push_back(v(C_NOP, 0, 13'h000, 0, 16'h7777, 0, 16'h0,    0, 0));
        tbl.push_back(v(C_NOP, 0, 13'h000, 0, 16'h8888, 0, 16'h0,    0, 0));
        tbl.push_back(v(C_RD,  0, 13'h004, 0, 0,        0, 16'h0,    0, 0));
        tbl.push_back(v(C_BT,  0, 13'h000, 0, 0,        0, 16'h0,    0, 0));
        tbl.push_back(v(C_NOP, 0, 13'h000, 0, 0,        1, 16'h1111, 0, 0));
        tbl.push_back(v(C_NOP, 0, 13'h000, 0, 0,        0, 16'h0,    0, 0));
        tbl.push_back(v(C_NOP, 0, 13'h000, 0, 0,        0, 16'h0,    0, 0));
        tbl.push_back(v(C_PRE, 0, 13'h400, 0, 0,        0, 16'h0,    0, 0));
        tbl.push_back(v(C_ACT, 1, 13'h002, 0, 0,        0, 16'h0,    0, 0));
        tbl.push_back(v(C_ACT, 1, 13'h003, 0, 0,        0, 16'h0,    1, 0));
        tbl.push_back(v(C_REF, 0, 13'h000, 0, 0,        0, 16'h0,    1, 0));
        tbl.push_back(v(C_PRE, 0, 13'h400, 0, 0,        0, 16'h0,    1, 0));
        tbl.push_back(v(C_REF, 0, 13'h000, 0, 0,        0, 16'h0,    1, 1));
        tbl.push_back(v(C_REF, 0, 13'h000, 0, 0,        0, 16'h0,    1, 2));
        tbl.push_back(v(C_REF, 0, 13'h000, 0, 0,        0, 16'h0,    1, 3));
        tbl.push_back(v(C_NOP, 0, 13'h000, 0, 0,        0, 16'h0,    1, 3));

        init = 1'b1;
        drive(C_NOP, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset doe",  16'(sd.sd_doe),  16'd0);
        chk("reset dout", sd.sd_dout,      16'd0);
        chk("reset err",  16'(err),        16'd0);
        chk("reset rcnt", refresh_cnt,     16'd0);
        @(negedge clk);
        init = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].cmd, tbl[i].ba, tbl[i].addr, tbl[i].dqm, tbl[i].din);
            chk($sformatf("row%0d doe", i),  16'(sd.sd_doe), 16'(tbl[i].doe));
            chk($sformatf("row%0d dout", i), sd.sd_dout,     tbl[i].dout);
            chk($sformatf("row%0d err", i),  16'(err),       16'(tbl[i].err));
            chk($sformatf("row%0d rcnt", i), refresh_cnt,    tbl[i].rcnt);
        end

        // Reset clears sticky err; then BL8 write with auto-precharge and an aborted BL8 read
        @(negedge clk);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        chk("re-reset err", 16'(err), 16'd0);
        step(C_LMR, 0, 13'h023, 0, 0);
        step(C_ACT, 2, 13'h001, 0, 0);
        step(C_WR,  2, 13'h400, 0, 16'h0100);
        for (int k = 1; k < 8; k++) step(C_NOP, 0, 0, 0, 16'h0100 + 16'(k));
        step(C_ACT, 2, 13'h001, 0, 0);
        chk("autopre reopen err", 16'(err), 16'd0);
        step(C_RD, 2, 13'h000, 0, 0);
        chk("bl8 n doe", 16'(sd.sd_doe), 16'd0);
        for (int k = 0; k < 3; k++) begin
            step(C_NOP, 0, 0, 0, 0);
            chk($sformatf("bl8 word%0d doe", k),  16'(sd.sd_doe), 16'd1);
            chk($sformatf("bl8 word%0d dout", k), sd.sd_dout,     16'h0100 + 16'(k));
        end
        #1;
        init = 1'b1;
        #1;
        chk("init abort doe",  16'(sd.sd_doe), 16'd0);
        chk("init abort dout", sd.sd_dout,     16'd0);
        @(negedge clk);
        init = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(C_NOP, 0, 0, 0, 0);
            chk($sformatf("post-init%0d doe", k),  16'(sd.sd_doe), 16'd0);
            chk($sformatf("post-init%0d dout", k), sd.sd_dout,     16'd0);
        end
        step(C_RD, 2, 13'h000, 0, 0);
        chk("read idle err", 16'(err), 16'd1);
        step(C_NOP, 0, 0, 0, 0);
        chk("read idle doe", 16'(sd.sd_doe), 16'd0);
        step(C_NOP, 0, 0, 0, 0);
        chk("read idle doe2", 16'(sd.sd_doe), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sdram_resp.md
SDRAM_RESP -- requirements
Module: sdram_resp

Interface
REQ-001 Parameter ROW_BITS, default 4, number of low row-address bits used to index backing store.
REQ-002 Parameter COL_BITS, default 4, number of low column-address bits used to index backing store.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 init  input  1  reset, asynchronous, active-high.
REQ-005 sd_cs, sd_ras, sd_cas, sd_we  input  1 each  negated command lines; command = {cs,ras,cas,we}.
REQ-006 sd_addr  input  13  multiplexed row/column/mode address; A10 = auto-precharge / all-banks flag.
REQ-007 sd_ba  input  2  bank select.
REQ-008 sd_dqm  input  2  write byte masks; dqm[1] masks [15:8], dqm[0] masks [7:0]; 1 = masked.
REQ-009 sd_din  input  16  data from controller.
REQ-010 sd_dout  output  16  read data to controller.
REQ-011 sd_doe  output  1  high while sd_dout carries valid read data.
REQ-012 err  output  1  sticky protocol-violation flag.
REQ-013 refresh_cnt  output  16  count of accepted AUTO_REFRESH commands.

Function
REQ-014 Decode: 1xxx INHIBIT, 0111 NOP, 0011 ACTIVE, 0101 READ, 0100 WRITE, 0110 BURST_TERMINATE, 0010 PRECHARGE, 0001 AUTO_REFRESH, 0000 LOAD_MODE; INHIBIT/NOP have no effect.
REQ-015 Per-bank state IDLE/ACTIVE plus open-row register; four banks independent.
REQ-016 Backing store 2^(2+ROW_BITS+COL_BITS) x 16, index {ba, open_row[ROW_BITS-1:0], col[COL_BITS-1:0]}.
REQ-017 ACTIVE on IDLE bank: latch sd_addr as row, bank -> ACTIVE; on ACTIVE bank: set err, no state change.
REQ-018 PRECHARGE: A10=1 -> all banks IDLE; A10=0 -> bank sd_ba IDLE; precharging an IDLE bank is legal.
REQ-019 AUTO_REFRESH with all banks IDLE: refresh_cnt +1, wrapping 0xFFFF -> 0; any bank ACTIVE: err, no count.
REQ-020 LOAD_MODE with all banks IDLE: latch CL=A[6:4], BL=A[2:0], write-single=A[9]; CL not 2/3 or BL not 000-011: err, mode unchanged; any bank ACTIVE: err, mode unchanged.
REQ-021 BL encoding 000/001/010/011 = 1/2/4/8 words; sequential only, A[3] ignored.
REQ-022 READ/WRITE on IDLE bank: err, command ignored.
REQ-023 READ at edge N: word k (k=0..BL-1) driven on sd_dout with sd_doe=1 during cycle after edge N+CL-1+k, sampled by controller at edge N+CL+k.
REQ-024 Burst column = start column with low log2(BL) bits incrementing and wrapping inside BL-aligned block.
REQ-025 WRITE at edge N: sd_din written at edge N honouring sd_dqm; further words at N+1..N+BL-1 unless write-single=1 (one word only).
REQ-026 Read data ignores sd_dqm.
REQ-027 New READ/WRITE/BURST_TERMINATE/PRECHARGE of burst bank terminates current burst; read words already in CL pipeline still emerge, no further words issued.
REQ-028 WRITE and pending read data colliding on the bus: write wins, sd_doe drops, no err.
REQ-029 A10=1 on READ/WRITE: bank -> IDLE after final burst word (auto-precharge).
REQ-030 sd_doe=0 and sd_dout=0 whenever no read word is valid.
REQ-031 Accesses use the bank's open row regardless of sd_addr row bits.

Reset
REQ-032 init=1 immediately: banks IDLE, CL=2, BL=1, write-single=0, err=0, refresh_cnt=0, sd_doe=0, sd_dout=0, bursts and read pipeline cleared.
REQ-033 init mid-burst aborts burst with no further store writes or read data; store contents not reset.

Verification
REQ-034 LOAD_MODE A=0x220, ACTIVE b0 row 5, WRITE col 3 din 0xA55A dqm 00, READ col 3 -> sd_doe high at N+1, data 0xA55A sampled at N+2.
REQ-035 LOAD_MODE A=0x032 (CL3, BL4), write four words, READ col 6 -> words at cols 6,7,4,5 on edges N+3..N+6.
REQ-036 WRITE 0x1234 then WRITE 0xFFFF dqm=10, READ -> 0x12FF.
REQ-037 ACTIVE b1 twice -> err=1 and stays 1; AUTO_REFRESH with b1 open -> refresh_cnt unchanged; PRECHARGE A10=1 then 3x AUTO_REFRESH -> refresh_cnt=3.
REQ-038 BL=8 read, assert init at 3rd data word -> sd_doe=0, sd_dout=0 same cycle, no further words; READ on IDLE bank afterwards -> err=1.
